imap_biu: RTL and testbench
===========================

Name: imap_biu

Overview:
- Input feature map bus interface unit: the read-side counterpart of the output-map writer.
- On a start pulse, walks in_ch × map_size 32-bit words from imap_base_addr and issues read requests to the memory arbiter.
- Buffers the returned read data in a credit-protected FIFO and streams it to the line buffer over valid/ready.

Parameters:
- FIFO_DEPTH, 8, return-data FIFO entries (power of two, ≥2); also the maximum number of outstanding reads.
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_ch  in  8  number of input channels.
- map_size  in  16  words per channel.
- imap_base_addr  in  ADDR_W  byte base address of the map.
- imap_read_req  in  1  start pulse.
- imap_busy  out  1  high from accepted start until done.
- imap_read_done  out  1  one-cycle completion pulse.
- imap_biu2arb_req  out  1  bus request to arbiter.
- imap_biu2arb_addr  out  ADDR_W  read address.
- imap_biu2arb_vld  out  1  read command valid.
- imap_biu2arb_rdy  in  1  read command accepted.
- arb2imap_biu_data  in  DATA_W  read return data.
- arb2imap_biu_vld  in  1  return valid; no back-pressure, returns arrive in order.
- imap_biu2line_buf_data  out  DATA_W  data to line buffer.
- imap_biu2line_buf_vld  out  1  FIFO not empty.
- imap_biu2line_buf_rdy  in  1  line buffer ready.

Behaviour:
- Reset: synchronous, active-high, all state cleared. All outputs are 0 and the FSM is in IDLE.
- Reset mid-operation: aborts the transfer, flushes the FIFO and clears the outstanding count. Any returns arriving after reset are ignored while IDLE.
- Transfer length: total = in_ch × map_size, 24-bit product.
- Addressing: addr = imap_base_addr + (word_cnt << 2). Computed at ADDR_W width, wraps modulo 2^ADDR_W.
- FSM IDLE:
  - imap_read_req latches the config and word_cnt = 0.
  - total == 0: pulse imap_read_done the next cycle and stay IDLE, with busy staying low.
  - Otherwise go to ISSUE, with busy = 1 from the next cycle.
- FSM ISSUE:
  - vld = (outstanding + fifo_count) < FIFO_DEPTH.
  - A vld&&rdy handshake increments word_cnt and outstanding.
  - The handshake on word total-1 moves the FSM to DRAIN.
  - addr and vld stay stable while vld && !rdy.
- FSM DRAIN: vld = 0. When outstanding == 0 and the FIFO is empty, pulse done for 1 cycle, drop busy and return to IDLE.
- imap_biu2arb_req = 1 in ISSUE, and in DRAIN while outstanding > 0.
- Return path: each arb2imap_biu_vld writes the FIFO and decrements outstanding.
  - A simultaneous issue-handshake and return leaves outstanding unchanged.
  - Simultaneous FIFO push and pop leaves the count unchanged.
  - The credit rule guarantees no overflow; a push while full is an assertion failure.
- Downstream: vld = FIFO not empty, with data = FIFO head. First-word latency is 1 cycle after the return (registered FIFO write).
- imap_read_req while busy is ignored.
- Sticky error: arb2imap_biu_vld while outstanding == 0 is dropped and flagged by a simulation assertion.

Optional Feature:
- Macro: IMAP_BIU_PERF_EN.
- When defined:
  - Adds output imap_perf_stall [31:0], counting cycles with imap_biu2arb_vld && !imap_biu2arb_rdy.
  - Adds output imap_perf_credit_stall [31:0], counting ISSUE cycles with vld = 0.
  - Both counters clear on an accepted start and on reset, and saturate at all-ones.
- When undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package (acc_pkg):
  - constants DATA_W and ADDR_W;
  - word-to-byte shift WORD_SHIFT = 2;
  - FSM state typedef {IDLE, ISSUE, DRAIN}, also reused by the output-map writer.
- One sub-module: imap_biu_fifo. Synchronous single-clock FIFO (DEPTH, DATA_W) with push, pop, full, empty and count outputs, and pointers one bit wider than the address.

Test Plan:
- Basic transfer:
  - Stimulus: in_ch=2, map_size=3, base=0x1000, rdy=1, return latency 2 cycles, line buffer rdy=1.
  - Response: addresses 0x1000 through 0x1014 in order, 6 words delivered in order, one done pulse, busy low afterwards.
- Credit limit:
  - Stimulus: map_size=20, in_ch=1, returns delayed 30 cycles, line buffer rdy=0.
  - Response: exactly 8 commands issued, then vld held 0 until line buffer rdy=1 drains entries; all 20 words delivered, no overflow assertion.
- Arbiter back-pressure:
  - Stimulus: rdy toggles 0/1 every cycle.
  - Response: addr and vld stable while stalled; with IMAP_BIU_PERF_EN, imap_perf_stall equals the number of stalled cycles.
- Zero length:
  - Stimulus: in_ch=0, map_size=100, start.
  - Response: done the cycle after start, no vld, busy never high.
- Simultaneous events and ignored start:
  - Stimulus: FIFO push and pop in the same cycle with a command handshake coincident with a return; also a start pulse issued while busy.
  - Response: counts unchanged; the start while busy is ignored.
- Address wrap and reset:
  - Stimulus: base=0xFFFFFFF8, map_size=4, in_ch=1.
  - Response: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - Follow-up: rst asserted mid-ISSUE returns all outputs to 0 the next cycle, and the FIFO empties.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared accelerator definitions: bus widths, word-to-byte addressing and the
// bus-interface FSM encoding used by both the input-map reader and output-map writer.
package acc_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int WORD_SHIFT = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t DRAIN = 2'd2;

endpackage

// File: rtl/imap_biu_fifo.sv
// Single-clock return-data FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy register.
module imap_biu_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = acc_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/imap_biu.sv
// Input feature map bus interface unit: issues credit-limited word reads and streams
// the returns to the line buffer. Optional perf counters: define IMAP_BIU_PERF_EN.
module imap_biu #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = acc_pkg::DATA_W,
    parameter int ADDR_W     = acc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_ch,
    input  logic [15:0]       map_size,
    input  logic [ADDR_W-1:0] imap_base_addr,
    input  logic              imap_read_req,
    output logic              imap_busy,
    output logic              imap_read_done,
    output logic              imap_biu2arb_req,
    output logic [ADDR_W-1:0] imap_biu2arb_addr,
    output logic              imap_biu2arb_vld,
    input  logic              imap_biu2arb_rdy,
    input  logic [DATA_W-1:0] arb2imap_biu_data,
    input  logic              arb2imap_biu_vld,
    output logic [DATA_W-1:0] imap_biu2line_buf_data,
    output logic              imap_biu2line_buf_vld,
    input  logic              imap_biu2line_buf_rdy
`ifdef IMAP_BIU_PERF_EN
    ,
    output logic [31:0]       imap_perf_stall,
    output logic [31:0]       imap_perf_credit_stall
`endif
);

    import acc_pkg::*;

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW+1)'(FIFO_DEPTH);

    state_t            state;
    logic [23:0]       total;
    logic [23:0]       word_cnt;
    logic [23:0]       req_total;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              done;
    logic              issue_hs;
    logic              ret_ok;
    logic              pop;

    assign req_total = 24'(in_ch) * 24'(map_size);
    // Credits cover both in-flight reads and buffered words, so a return can never overflow.
    assign imap_biu2arb_vld  = (state == ISSUE) &&
                               (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
    assign imap_biu2arb_addr = base + (ADDR_W'(word_cnt) << WORD_SHIFT);
    assign imap_biu2arb_req  = (state == ISSUE) || ((state == DRAIN) && (outstanding != '0));
    assign imap_busy         = (state != IDLE);
    assign imap_read_done    = done;

    assign issue_hs = imap_biu2arb_vld && imap_biu2arb_rdy;
    assign ret_ok   = arb2imap_biu_vld && (outstanding != '0);
    assign pop      = imap_biu2line_buf_vld && imap_biu2line_buf_rdy;

    assign imap_biu2line_buf_vld  = !fifo_empty;
    assign imap_biu2line_buf_data = fifo_empty ? '0 : fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            total       <= '0;
            word_cnt    <= '0;
            base        <= '0;
            outstanding <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (imap_read_req) begin
                    base     <= imap_base_addr;
                    total    <= req_total;
                    word_cnt <= '0;
                    if (req_total == '0) done  <= 1'b1;
                    else                 state <= ISSUE;
                end
                ISSUE: if (issue_hs) begin
                    word_cnt <= word_cnt + 24'd1;
                    if (word_cnt == total - 24'd1) state <= DRAIN;
                end
                DRAIN: if (outstanding == '0 && fifo_empty) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            case ({issue_hs, ret_ok})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    imap_biu_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_ok),
        .push_data (arb2imap_biu_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef IMAP_BIU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && imap_read_req)) begin
            imap_perf_stall        <= '0;
            imap_perf_credit_stall <= '0;
        end else begin
            if (imap_biu2arb_vld && !imap_biu2arb_rdy && imap_perf_stall != '1)
                imap_perf_stall <= imap_perf_stall + 32'd1;
            if (state == ISSUE && !imap_biu2arb_vld && imap_perf_credit_stall != '1)
                imap_perf_credit_stall <= imap_perf_credit_stall + 32'd1;
        end
    end
`endif

    // Unsolicited returns are dropped by ret_ok; these flag them and any credit breach.
    a_no_spurious_return: assert property (@(posedge clk) disable iff (rst)
        !(arb2imap_biu_vld && outstanding == '0 && state != IDLE));
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ret_ok && fifo_full));

endmodule

// File: tb/tb_imap_biu.sv
// Self-checking bench for imap_biu: a transaction-level model (issued/returned/popped
// counts and a memory function) checked every cycle, plus directed literal checks.
module tb_imap_biu;

    localparam int DEPTH = 8;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_ch = '0;
    logic [15:0] map_size = '0;
    logic [31:0] base = '0;
    logic        read_req = 1'b0;
    logic        busy, done, arb_req, arb_vld, lb_vld;
    logic [31:0] arb_addr, lb_data;
    logic        arb_rdy = 1'b1;
    logic [31:0] ret_data = '0;
    logic        ret_vld = 1'b0;
    logic        lb_rdy = 1'b0;
`ifdef IMAP_BIU_PERF_EN
    logic [31:0] perf_stall, perf_credit;
`endif

    // Stimulus knobs written only by the sequence process.
    int ret_lat = 2;
    bit rdy_toggle = 1'b0;

    // Model and logs written only by the monitor process.
    int          errors = 0;
    int          checks = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_total = 0, m_issued = 0, m_returned = 0, m_popped = 0;
    int          m_stall = 0, m_cstall = 0;
    logic [31:0] m_base = '0;
    ret_t        ret_q[$];
    logic [31:0] addr_log[$];
    int          deliv_cnt = 0, done_cnt = 0, vld_cnt = 0, busy_cnt = 0;

    always #5 clk = ~clk;

    imap_biu dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_ch                  (in_ch),
        .map_size               (map_size),
        .imap_base_addr         (base),
        .imap_read_req          (read_req),
        .imap_busy              (busy),
        .imap_read_done         (done),
        .imap_biu2arb_req       (arb_req),
        .imap_biu2arb_addr      (arb_addr),
        .imap_biu2arb_vld       (arb_vld),
        .imap_biu2arb_rdy       (arb_rdy),
        .arb2imap_biu_data      (ret_data),
        .arb2imap_biu_vld       (ret_vld),
        .imap_biu2line_buf_data (lb_data),
        .imap_biu2line_buf_vld  (lb_vld),
        .imap_biu2line_buf_rdy  (lb_rdy)
`ifdef IMAP_BIU_PERF_EN
        ,
        .imap_perf_stall        (perf_stall),
        .imap_perf_credit_stall (perf_credit)
`endif
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] ch, input logic [15:0] ms, input logic [31:0] b);
        in_ch = ch; map_size = ms; base = b; read_req = 1'b1;
        tick(1);
        read_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check("done_timeout", {31'd0, done === 1'b1}, 32'd1);
    endtask

    // Monitor: compare against the model, play the arbiter, then advance the model
    // with the input values the coming edge will sample.
    initial begin : monitor
        int  n;
        bit  nd, hs, exp_vld, exp_req, exp_lvld;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            exp_vld  = m_busy && (m_issued < m_total) && ((m_issued - m_popped) < DEPTH);
            exp_req  = m_busy && ((m_issued < m_total) || (m_returned < m_issued));
            exp_lvld = (m_returned > m_popped);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("arb_vld", {31'd0, arb_vld}, {31'd0, exp_vld});
            check("arb_req", {31'd0, arb_req}, {31'd0, exp_req});
            check("lb_vld", {31'd0, lb_vld}, {31'd0, exp_lvld});
            if (exp_vld)  check("arb_addr", arb_addr, m_base + 32'(m_issued << 2));
            if (exp_lvld) check("lb_data", lb_data, memfn(m_base + 32'(m_popped << 2)));
`ifdef IMAP_BIU_PERF_EN
            check("perf_stall", perf_stall, 32'(m_stall));
            check("perf_credit", perf_credit, 32'(m_cstall));
`endif
            if (done)    done_cnt++;
            if (arb_vld) vld_cnt++;
            if (busy)    busy_cnt++;

            if (rst) begin
                ret_q.delete();
                ret_vld  = 1'b0;
                ret_data = '0;
            end else if (ret_q.size() > 0 && ret_q[0].due <= n) begin
                ret_vld  = 1'b1;
                ret_data = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                ret_vld  = 1'b0;
                ret_data = '0;
            end
            arb_rdy = rdy_toggle ? n[0] : 1'b1;

            if (rst) begin
                m_busy = 0; m_done = 0; m_total = 0; m_issued = 0;
                m_returned = 0; m_popped = 0; m_stall = 0; m_cstall = 0; m_base = '0;
            end else begin
                nd = 0;
                hs = arb_vld && arb_rdy;
                if (hs) begin
                    ret_q.push_back('{due: n + ret_lat, data: memfn(arb_addr)});
                    addr_log.push_back(arb_addr);
                end
                if (arb_vld && !arb_rdy) m_stall++;
                if (m_busy && (m_issued < m_total) && !arb_vld) m_cstall++;
                if (m_busy && m_popped == m_total) begin
                    m_busy = 0;
                    nd = 1;
                end else if (!m_busy && read_req) begin
                    m_base = base; m_total = int'(in_ch) * int'(map_size);
                    m_issued = 0; m_returned = 0; m_popped = 0; m_stall = 0; m_cstall = 0;
                    if (m_total == 0) nd = 1;
                    else              m_busy = 1;
                end
                if (hs)      m_issued++;
                if (ret_vld) m_returned++;
                if (lb_vld && lb_rdy) begin
                    m_popped++;
                    deliv_cnt++;
                end
                m_done = nd;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        int a0, d0, c0, v0, b0;
        tick(3);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_req", {31'd0, arb_req}, 32'd0);
        check("rst_vld", {31'd0, arb_vld}, 32'd0);
        check("rst_addr", arb_addr, 32'd0);
        check("rst_lb_vld", {31'd0, lb_vld}, 32'd0);
        check("rst_lb_data", lb_data, 32'd0);

        // Basic transfer with overlapping issue/return/pop, plus a start while busy.
        ret_lat = 2; rdy_toggle = 0; lb_rdy = 1'b1;
        a0 = addr_log.size(); d0 = deliv_cnt; c0 = done_cnt;
        start(8'd2, 16'd3, 32'h0000_1000);
        tick(3);
        start(8'd5, 16'd1, 32'hDEAD_0000);
        wait_done(100);
        tick(2);
        check("t1_cmds", 32'(addr_log.size() - a0), 32'd6);
        check("t1_addr0", addr_log[a0], 32'h0000_1000);
        check("t1_addr5", addr_log[a0 + 5], 32'h0000_1014);
        check("t1_words", 32'(deliv_cnt - d0), 32'd6);
        check("t1_dones", 32'(done_cnt - c0), 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Credit limit: slow returns, line buffer stalled.
        ret_lat = 30; lb_rdy = 1'b0;
        a0 = addr_log.size(); d0 = deliv_cnt;
        start(8'd1, 16'd20, 32'h0000_2000);
        tick(20);
        check("t2_cmds_cap", 32'(addr_log.size() - a0), 32'd8);
        check("t2_vld_held", {31'd0, arb_vld}, 32'd0);
        tick(30);
        check("t2_cmds_full", 32'(addr_log.size() - a0), 32'd8);
        check("t2_lb_vld", {31'd0, lb_vld}, 32'd1);
        check("t2_vld_full", {31'd0, arb_vld}, 32'd0);
        lb_rdy = 1'b1;
        wait_done(400);
        tick(2);
        check("t2_cmds", 32'(addr_log.size() - a0), 32'd20);
        check("t2_words", 32'(deliv_cnt - d0), 32'd20);

        // Arbiter back-pressure: rdy alternates every cycle.
        ret_lat = 3; rdy_toggle = 1;
        a0 = addr_log.size();
        start(8'd1, 16'd5, 32'h0000_3000);
        wait_done(200);
        tick(2);
        rdy_toggle = 0;
        check("t3_cmds", 32'(addr_log.size() - a0), 32'd5);
        check("t3_addr4", addr_log[a0 + 4], 32'h0000_3010);

        // Zero length.
        v0 = vld_cnt; b0 = busy_cnt; c0 = done_cnt;
        start(8'd0, 16'd100, 32'h0000_4000);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        tick(3);
        check("t4_done_once", 32'(done_cnt - c0), 32'd1);
        check("t4_no_vld", 32'(vld_cnt - v0), 32'd0);
        check("t4_no_busy", 32'(busy_cnt - b0), 32'd0);

        // Address wrap.
        ret_lat = 2; lb_rdy = 1'b1;
        a0 = addr_log.size();
        start(8'd1, 16'd4, 32'hFFFF_FFF8);
        wait_done(100);
        tick(2);
        check("t5_addr0", addr_log[a0], 32'hFFFF_FFF8);
        check("t5_addr1", addr_log[a0 + 1], 32'hFFFF_FFFC);
        check("t5_addr2", addr_log[a0 + 2], 32'h0000_0000);
        check("t5_addr3", addr_log[a0 + 3], 32'h0000_0004);

        // Reset mid-ISSUE with data buffered, then a clean transfer afterwards.
        lb_rdy = 1'b0;
        start(8'd1, 16'd20, 32'h0000_5000);
        tick(5);
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        check("t6_lb_vld_pre", {31'd0, lb_vld}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_req", {31'd0, arb_req}, 32'd0);
        check("t6_vld", {31'd0, arb_vld}, 32'd0);
        check("t6_addr", arb_addr, 32'd0);
        check("t6_lb_vld", {31'd0, lb_vld}, 32'd0);
        check("t6_lb_data", lb_data, 32'd0);
        tick(8);
        check("t6_lb_vld_late", {31'd0, lb_vld}, 32'd0);
        lb_rdy = 1'b1;
        a0 = addr_log.size(); d0 = deliv_cnt;
        start(8'd1, 16'd2, 32'h0000_6000);
        wait_done(100);
        tick(2);
        check("t6_post_addr1", addr_log[a0 + 1], 32'h0000_6004);
        check("t6_post_words", 32'(deliv_cnt - d0), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
